// File: rtl/qdec_pkg.sv
// qdec_pkg: index-mode selectors and FSM state encodings shared by the quadrature decoder
package qdec_pkg;
   localparam int Z_MODE_OFF   = 0;
   localparam int Z_MODE_EVERY = 1;
   localparam int Z_MODE_ARMED = 2;
   typedef logic [0:0] qdec_state_t;
   localparam qdec_state_t S_INIT = 1'b0;
   localparam qdec_state_t S_RUN  = 1'b1;
endpackage

// File: rtl/qdec_filter.sv
// qdec_filter: synchroniser chain plus stability filter for one asynchronous encoder input
module qdec_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic f_o,
   output logic f_d_o
);
   localparam int FW = $clog2(FILT_LEN + 1);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic                   f_q, f_d, s, accept;
   assign s = sync_q[SYNC_STAGES-1];
   // A level is accepted on the FILT_LEN-th consecutive cycle it disagrees with f_q
   always_comb begin
      accept = (s != f_q) && (fcnt_q == FW'(FILT_LEN - 1));
      f_d    = accept ? s : f_q;
      fcnt_d = ((s == f_q) || accept) ? '0 : fcnt_q + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         fcnt_q <= '0;
         f_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         fcnt_q <= fcnt_d;
         f_q    <= f_d;
      end
   end
   assign f_o   = f_q;
   assign f_d_o = f_d;
endmodule

// File: rtl/qdec_counter.sv
// qdec_counter: quadrature decoder with filtered inputs, wrapping position count,
// direction, step/error strobes and optional index-pulse clearing
module qdec_counter
   import qdec_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int Z_MODE      = Z_MODE_EVERY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             z,
   input  logic             clr,
   input  logic             z_arm,
   output logic [CNT_W-1:0] cnt,
   output logic             dir,
   output logic             step,
   output logic             err,
   output logic             armed,
   output logic             ready
);
   localparam int INIT_CYC = SYNC_STAGES + FILT_LEN;
   localparam int IW       = $clog2(INIT_CYC);
   logic [2:0]       raw, flt, flt_d, prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, delta;
   logic [IW-1:0]    ic_q, ic_d;
   qdec_state_t      state_q, state_d;
   logic             dir_q, dir_d, step_q, err_q, armed_q, armed_d;
   logic             run, ch_a, ch_b, one, both, fwd, idx_clr;
   assign raw = {z, b, a};
   for (genvar i = 0; i < 3; i++) begin : g_flt
      qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_flt (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   (raw[i]),
         .f_o   (flt[i]),
         .f_d_o (flt_d[i])
      );
   end
   // INIT tracks the filters' next value so prev matches the settled level on entry to RUN
   always_comb begin
      run     = state_q == S_RUN;
      ch_a    = flt[0] ^ prev_q[0];
      ch_b    = flt[1] ^ prev_q[1];
      one     = run && (ch_a ^ ch_b);
      both    = run && ch_a && ch_b;
      fwd     = flt[1] ^ prev_q[0];
      idx_clr = run && flt[2] && !prev_q[2] &&
                (Z_MODE == Z_MODE_EVERY || (Z_MODE == Z_MODE_ARMED && armed_q));
      delta   = one ? (fwd ? CNT_W'(1) : '1) : both ? (dir_q ? CNT_W'(2) : ~CNT_W'(1)) : '0;
      cnt_d   = ((run && clr) || idx_clr) ? '0 : cnt_q + delta;
      dir_d   = one ? fwd : dir_q;
      armed_d = (Z_MODE == Z_MODE_ARMED) && (z_arm || (armed_q && !idx_clr));
      state_d = (run || ic_q == IW'(INIT_CYC - 1)) ? S_RUN : S_INIT;
      ic_d    = run ? ic_q : ic_q + 1'b1;
      prev_d  = run ? flt : flt_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         ic_q    <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ic_q    <= ic_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         step_q  <= one || both;
         err_q   <= both;
         armed_q <= armed_d;
      end
   end
   assign cnt   = cnt_q;
   assign dir   = dir_q;
   assign step  = step_q;
   assign err   = err_q;
   assign armed = armed_q;
   assign ready = state_q == S_RUN;
endmodule

// File: tb/tb_qdec_counter.sv
// tb_qdec_counter: directed vectors for the quadrature decoder (armed-index unit plus
// an every-index unit sharing the same stimulus)
module tb_qdec_counter;
   logic        clk = 1'b0, rst_n = 1'b0, a = 1'b1, b = 1'b1, z = 1'b0, clr = 1'b0, z_arm = 1'b0;
   logic [15:0] cnt, cnt1;
   logic        dir, step, err, armed, ready, dir1, step1, err1, armed1, ready1;
   int          checks = 0, errors = 0, nstep = 0, nerr = 0, base_s, base_e;
   typedef struct {logic a; logic b; logic [15:0] cnt; logic dir;} vec_t;
   vec_t        tab[33];
   logic [1:0]  fseq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic [1:0]  rseq[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   always #5 clk = ~clk;
   qdec_counter #(.CNT_W(16), .SYNC_STAGES(2), .FILT_LEN(4), .Z_MODE(2)) u0 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z), .clr(clr), .z_arm(z_arm),
      .cnt(cnt), .dir(dir), .step(step), .err(err), .armed(armed), .ready(ready));
   qdec_counter #(.CNT_W(16), .SYNC_STAGES(2), .FILT_LEN(4), .Z_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z), .clr(clr), .z_arm(z_arm),
      .cnt(cnt1), .dir(dir1), .step(step1), .err(err1), .armed(armed1), .ready(ready1));
   always @(negedge clk) begin
      if (rst_n && step) nstep++;
      if (rst_n && err) nerr++;
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic edge_chk(input logic na, input logic nb, input logic [15:0] ec, input logic ed, input string nm);
      a = na;
      b = nb;
      tick(8);
      chk({nm, "_cnt"}, cnt, ec);
      chk({nm, "_dir"}, dir, ed);
   endtask
   task automatic pulse_arm();
      z_arm = 1'b1;
      tick(1);
      z_arm = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 16; i++) tab[i] = '{fseq[i % 4][1], fseq[i % 4][0], 16'(i + 1), 1'b1};
      for (int i = 0; i < 17; i++) tab[16 + i] = '{rseq[i % 4][1], rseq[i % 4][0], 16'(15 - i), 1'b0};
      // reset and INIT timing with A/B high
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_cnt", cnt, 0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      chk("init_ready5", ready, 0);
      tick(1);
      chk("init_ready6", ready, 1);
      tick(10);
      chk("idle_cnt", cnt, 0);
      chk("idle_steps", nstep, 0);
      chk("idle_errs", nerr, 0);
      // exact latency of one clean edge, then clr in RUN
      b = 1'b0;
      tick(6);
      chk("lat_early", cnt, 0);
      tick(1);
      chk("lat_exact", cnt, 1);
      chk("lat_step", step, 1);
      tick(1);
      chk("step_pulse_end", step, 0);
      edge_chk(0, 0, 2, 1, "fwd_pre");
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk("clr_cnt", cnt, 0);
      // table: 16 forward, 17 reverse edges
      base_s = nstep;
      for (int i = 0; i < 33; i++) begin
         edge_chk(tab[i].a, tab[i].b, tab[i].cnt, tab[i].dir, $sformatf("tab%0d", i));
         if (i == 15) chk("fwd_steps", nstep - base_s, 16);
      end
      chk("tab_steps", nstep - base_s, 33);
      // glitches on A
      base_s = nstep;
      a = 1'b0;
      tick(3);
      a = 1'b1;
      tick(10);
      chk("glitch3_cnt", cnt, 16'hFFFF);
      a = 1'b0;
      tick(4);
      a = 1'b1;
      tick(4);
      chk("glitch4_fall_cnt", cnt, 0);
      chk("glitch4_fall_dir", dir, 1);
      tick(8);
      chk("glitch4_rise_cnt", cnt, 16'hFFFF);
      chk("glitch4_rise_dir", dir, 0);
      chk("glitch_steps", nstep - base_s, 2);
      // skipped step: +2 with dir=1, -2 with dir=0
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      edge_chk(0, 0, 1, 1, "e1");
      edge_chk(0, 1, 2, 1, "e2");
      edge_chk(1, 1, 3, 1, "e3");
      edge_chk(1, 0, 4, 1, "e4");
      edge_chk(0, 0, 5, 1, "e5");
      base_e = nerr;
      a = 1'b1;
      b = 1'b1;
      tick(7);
      chk("skip_err", err, 1);
      chk("skip_step", step, 1);
      chk("skip_cnt", cnt, 7);
      tick(1);
      chk("skip_err_end", err, 0);
      chk("skip_dir", dir, 1);
      edge_chk(0, 1, 6, 0, "rev1");
      edge_chk(1, 0, 4, 0, "skip_rev");
      chk("skip_errs", nerr - base_e, 2);
      // index handling
      z = 1'b1;
      tick(8);
      chk("z_unarmed_cnt", cnt, 4);
      chk("z_every_cnt", cnt1, 0);
      z = 1'b0;
      tick(8);
      pulse_arm();
      chk("arm_set", armed, 1);
      chk("arm_every", armed1, 0);
      z = 1'b1;
      tick(8);
      chk("z_armed_cnt", cnt, 0);
      chk("z_armed_clr", armed, 0);
      z = 1'b0;
      tick(8);
      edge_chk(1, 1, 16'hFFFF, 0, "zrev");
      pulse_arm();
      z = 1'b1;
      edge_chk(1, 0, 0, 1, "z_step");
      chk("z_step_armed", armed, 0);
      chk("z_step_every", cnt1, 0);
      // clr and index together with a reverse step
      z = 1'b0;
      tick(8);
      edge_chk(0, 0, 1, 1, "c1");
      edge_chk(0, 1, 2, 1, "c2");
      pulse_arm();
      b = 1'b0;
      z = 1'b1;
      tick(6);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk("clr_idx_cnt", cnt, 0);
      chk("clr_idx_dir", dir, 0);
      chk("clr_idx_step", step, 1);
      chk("clr_idx_armed", armed, 0);
      // reset in the middle of motion
      edge_chk(0, 1, 1, 1, "m1");
      a = 1'b1;
      tick(3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", cnt, 0);
      chk("mid_rst_dir", dir, 0);
      chk("mid_rst_ready", ready, 0);
      chk("mid_rst_step", step, 0);
      tick(2);
      rst_n = 1'b1;
      pulse_arm();
      chk("init_arm", armed, 1);
      tick(4);
      chk("reinit_ready5", ready, 0);
      tick(1);
      chk("reinit_ready6", ready, 1);
      tick(10);
      chk("reinit_cnt", cnt, 0);
      chk("reinit_armed", armed, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
